// File: rtl/fp_pkg.sv
// Shared widths, constants and FSM encoding for the single-precision FP add datapath.
package fp_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned GRS_W  = 3;
  localparam int unsigned MANT_W = FRAC_W + 1;
  localparam int unsigned SH_W   = MANT_W + GRS_W;

  localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;

  typedef enum logic [1:0] {
    StIdle,
    StCmp,
    StShift,
    StDone
  } align_state_e;

  // Subnormals behave as exponent 1 with a zero hidden bit.
  function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
    return (e == '0) ? EXP_W'(1) : e;
  endfunction

endpackage

// File: rtl/shift_right_sticky.sv
// Right shift of the extended significand, folding every lost bit into the sticky LSB.
module shift_right_sticky
  import fp_pkg::*;
(
  input  logic [SH_W-1:0]  din_i,
  input  logic [EXP_W-1:0] amt_i,
  output logic [SH_W-1:0]  dout_o
);

  logic [SH_W-1:0] shifted;
  logic [SH_W-1:0] lost_mask;
  logic            sticky;

  always_comb begin
    shifted   = '0;
    lost_mask = '0;
    sticky    = 1'b0;
    if (amt_i >= EXP_W'(SH_W)) begin
      dout_o = {{(SH_W-1){1'b0}}, |din_i};
    end else begin
      shifted   = din_i >> amt_i;
      lost_mask = ~({SH_W{1'b1}} << amt_i);
      sticky    = |(din_i & lost_mask);
      dout_o    = {shifted[SH_W-1:1], shifted[0] | sticky};
    end
  end

endmodule

// File: rtl/fp_align_ctrl.sv
// Exponent alignment sequencer: picks the larger operand and right-shifts the other
// significand by the exponent difference, keeping guard/round/sticky bits.
module fp_align_ctrl
  import fp_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_a,
  input  logic [31:0]         in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [EXP_W-1:0]    out_exp,
  output logic                out_sign_big,
  output logic                out_sign_small,
  output logic [MANT_W-1:0]   out_mant_big,
  output logic [SH_W-1:0]     out_mant_small,
  output logic                out_swapped,
  output logic                out_special
);

  align_state_e state_q;
  logic [31:0]       a_q, b_q;
  logic [EXP_W-1:0]  exp_big_q, diff_q;
  logic              sign_big_q, sign_small_q, swapped_q, special_q;
  logic [MANT_W-1:0] mant_big_q, src_small_q;

  logic              in_ready_q, out_valid_q;
  logic [EXP_W-1:0]  out_exp_q;
  logic              out_sign_big_q, out_sign_small_q, out_swapped_q, out_special_q;
  logic [MANT_W-1:0] out_mant_big_q;
  logic [SH_W-1:0]   out_mant_small_q;

  logic [EXP_W-1:0]  exp_a, exp_b, eff_a, eff_b;
  logic [FRAC_W-1:0] frac_a, frac_b;
  logic              hid_a, hid_b, swap;
  logic [SH_W-1:0]   shifted;

  always_comb begin
    exp_a  = a_q[30:23];
    exp_b  = b_q[30:23];
    frac_a = a_q[22:0];
    frac_b = b_q[22:0];
    hid_a  = (exp_a != '0);
    hid_b  = (exp_b != '0);
    eff_a  = eff_exp(exp_a);
    eff_b  = eff_exp(exp_b);
    swap   = (eff_b > eff_a) || ((eff_b == eff_a) && (frac_b > frac_a));
  end

  shift_right_sticky u_shift (
    .din_i  ({src_small_q, {GRS_W{1'b0}}}),
    .amt_i  (diff_q),
    .dout_o (shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      a_q              <= '0;
      b_q              <= '0;
      exp_big_q        <= '0;
      diff_q           <= '0;
      sign_big_q       <= 1'b0;
      sign_small_q     <= 1'b0;
      swapped_q        <= 1'b0;
      special_q        <= 1'b0;
      mant_big_q       <= '0;
      src_small_q      <= '0;
      in_ready_q       <= 1'b1;
      out_valid_q      <= 1'b0;
      out_exp_q        <= '0;
      out_sign_big_q   <= 1'b0;
      out_sign_small_q <= 1'b0;
      out_swapped_q    <= 1'b0;
      out_special_q    <= 1'b0;
      out_mant_big_q   <= '0;
      out_mant_small_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            in_ready_q <= 1'b0;
            state_q    <= StCmp;
          end
        end
        StCmp: begin
          exp_big_q    <= swap ? eff_b : eff_a;
          diff_q       <= swap ? (eff_b - eff_a) : (eff_a - eff_b);
          sign_big_q   <= swap ? b_q[31] : a_q[31];
          sign_small_q <= swap ? a_q[31] : b_q[31];
          mant_big_q   <= swap ? {hid_b, frac_b} : {hid_a, frac_a};
          src_small_q  <= swap ? {hid_a, frac_a} : {hid_b, frac_b};
          swapped_q    <= swap;
          special_q    <= (exp_a == EXP_ALL_ONES) || (exp_b == EXP_ALL_ONES);
          state_q      <= StShift;
        end
        StShift: begin
          out_exp_q        <= exp_big_q;
          out_sign_big_q   <= sign_big_q;
          out_sign_small_q <= sign_small_q;
          out_mant_big_q   <= mant_big_q;
          out_mant_small_q <= special_q ? {src_small_q, {GRS_W{1'b0}}} : shifted;
          out_swapped_q    <= swapped_q;
          out_special_q    <= special_q;
          out_valid_q      <= 1'b1;
          state_q          <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_exp        = out_exp_q;
  assign out_sign_big   = out_sign_big_q;
  assign out_sign_small = out_sign_small_q;
  assign out_mant_big   = out_mant_big_q;
  assign out_mant_small = out_mant_small_q;
  assign out_swapped    = out_swapped_q;
  assign out_special    = out_special_q;

endmodule

// File: tb/tb_fp_align_ctrl.sv
// Directed-vector bench for fp_align_ctrl with hand-computed expected results.
module tb_fp_align_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_exp;
  logic        out_sign_big, out_sign_small;
  logic [23:0] out_mant_big;
  logic [26:0] out_mant_small;
  logic        out_swapped, out_special;

  int n_vec;
  int n_err;

  fp_align_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_a           (in_a),
    .in_b           (in_b),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_exp        (out_exp),
    .out_sign_big   (out_sign_big),
    .out_sign_small (out_sign_small),
    .out_mant_big   (out_mant_big),
    .out_mant_small (out_mant_small),
    .out_swapped    (out_swapped),
    .out_special    (out_special)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present an operand pair and wait (bounded) for out_valid; checks latency == 3.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input string tag);
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    lat      = 0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end
    check_eq({tag, ".latency"}, lat, 3);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, ".valid_drop"}, {31'b0, out_valid}, 0);
    check_eq({tag, ".ready_back"}, {31'b0, in_ready}, 1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag,
                        input logic [7:0] e_exp, input logic [23:0] e_big,
                        input logic [26:0] e_small, input logic e_swap, input logic e_spec,
                        input logic e_sb, input logic e_ss);
    launch(a, b, tag);
    check_eq({tag, ".exp"}, {24'b0, out_exp}, {24'b0, e_exp});
    check_eq({tag, ".mant_big"}, {8'b0, out_mant_big}, {8'b0, e_big});
    check_eq({tag, ".mant_small"}, {5'b0, out_mant_small}, {5'b0, e_small});
    check_eq({tag, ".swapped"}, {31'b0, out_swapped}, {31'b0, e_swap});
    check_eq({tag, ".special"}, {31'b0, out_special}, {31'b0, e_spec});
    check_eq({tag, ".signs"}, {30'b0, out_sign_big, out_sign_small}, {30'b0, e_sb, e_ss});
    handshake(tag);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst.in_ready", {31'b0, in_ready}, 1);
    check_eq("rst.out_valid", {31'b0, out_valid}, 0);
    check_eq("rst.out_exp", {24'b0, out_exp}, 0);
    check_eq("rst.mant_small", {5'b0, out_mant_small}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    //     a             b             tag        exp    big        small         sw spc sb ss
    run_op(32'h3F800000, 32'h3F000000, "diff1",   8'h7F, 24'h800000, 27'h2000000, 0, 0, 0, 0);
    run_op(32'h3F000000, 32'h3F800000, "diff1sw", 8'h7F, 24'h800000, 27'h2000000, 1, 0, 0, 0);
    run_op(32'h3F800000, 32'h33800001, "diff24",  8'h7F, 24'h800000, 27'h0000005, 0, 0, 0, 0);
    run_op(32'h4F000000, 32'h3F800000, "diff31",  8'h9E, 24'h800000, 27'h0000001, 0, 0, 0, 0);
    run_op(32'h4F000000, 32'h00000000, "bzero",   8'h9E, 24'h800000, 27'h0000000, 0, 0, 0, 0);
    run_op(32'h3FC00000, 32'h3FE00000, "eqexp",   8'h7F, 24'hE00000, 27'h6000000, 1, 0, 0, 0);
    run_op(32'hBF800000, 32'h3F000000, "sign",    8'h7F, 24'h800000, 27'h2000000, 0, 0, 1, 0);
    run_op(32'h7F800000, 32'h3F800000, "inf",     8'hFF, 24'h800000, 27'h4000000, 0, 1, 0, 0);

    // Both zero: no swap, zero significands
    launch(32'h00000000, 32'h00000000, "zz");
    check_eq("zz.mant_big", {8'b0, out_mant_big}, 0);
    check_eq("zz.mant_small", {5'b0, out_mant_small}, 0);
    check_eq("zz.swapped", {31'b0, out_swapped}, 0);
    handshake("zz");

    // Backpressure: results hold and a competing in_valid is ignored
    launch(32'h3F800000, 32'h33800001, "bp");
    in_valid = 1'b1;
    in_a     = 32'h40000000;
    in_b     = 32'h3F800000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp.hold_valid", {31'b0, out_valid}, 1);
      check_eq("bp.in_ready", {31'b0, in_ready}, 0);
      check_eq("bp.hold_small", {5'b0, out_mant_small}, 27'h0000005);
      check_eq("bp.hold_exp", {24'b0, out_exp}, 8'h7F);
    end
    in_valid = 1'b0;
    handshake("bp");
    repeat (4) @(negedge clk);
    check_eq("bp.no_queue", {31'b0, out_valid}, 0);
    check_eq("bp.idle_ready", {31'b0, in_ready}, 1);

    // Reset asserted while in SHIFT
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 32'h3F800000;
    in_b     = 32'h3F000000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rstmid.out_valid", {31'b0, out_valid}, 0);
    check_eq("rstmid.in_ready", {31'b0, in_ready}, 1);
    check_eq("rstmid.out_exp", {24'b0, out_exp}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("rstmid.discarded", {31'b0, out_valid}, 0);

    run_op(32'h3F800000, 32'h3F000000, "post", 8'h7F, 24'h800000, 27'h2000000, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
